// File: rtl/f2h_wr_burst_arbiter.sv
// Round-robin write-burst scheduler for the FPGA-to-HPS AXI3 slave write
// channels. One burst runs end to end at a time: AW issue, W beat streaming,
// B response, then a one-cycle completion pulse back to the owning requester.
//
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where valid and ready are both 1. A valid, once raised, keeps its payload
// stable until that transfer.
module f2h_wr_burst_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*4-1:0]        req_len,
    output logic [NUM_REQ-1:0]          req_grant,
    input  logic [NUM_REQ*DATA_W-1:0]   wr_data,
    input  logic [NUM_REQ*DATA_W/8-1:0] wr_strb,
    input  logic [NUM_REQ-1:0]          wr_valid,
    output logic [NUM_REQ-1:0]          wr_ready,
    output logic [NUM_REQ-1:0]          done_valid,
    output logic [1:0]                  done_resp,
    output logic [7:0]                  m_awid,
    output logic [ADDR_W-1:0]           m_awaddr,
    output logic [3:0]                  m_awlen,
    output logic                        m_awvalid,
    input  logic                        m_awready,
    output logic [2:0]                  m_awsize,
    output logic [1:0]                  m_awburst,
    output logic [1:0]                  m_awlock,
    output logic [3:0]                  m_awcache,
    output logic [2:0]                  m_awprot,
    output logic [4:0]                  m_awuser,
    output logic [7:0]                  m_wid,
    output logic [DATA_W-1:0]           m_wdata,
    output logic [DATA_W/8-1:0]         m_wstrb,
    output logic                        m_wlast,
    output logic                        m_wvalid,
    input  logic                        m_wready,
    input  logic [7:0]                  m_bid,
    input  logic [1:0]                  m_bresp,
    input  logic                        m_bvalid,
    output logic                        m_bready,
    output logic [2:0]                  o_dbg_state
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_AW_ISSUE = 3'd1,
        S_W_STREAM = 3'd2,
        S_B_WAIT   = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [ADDR_W-1:0]  r_addr;
    logic [3:0]         r_len;
    logic [3:0]         r_beat_cnt;
    logic [1:0]         r_bresp;
    logic               w_any;
    logic [IDX_W-1:0]   w_pick;
    logic [NUM_REQ-1:0] w_onehot;
    logic               w_unused_bid;

    // Single burst outstanding, so the returned ID carries no information.
    assign w_unused_bid = ^m_bid;

    // Fixed AXI attributes: 8-byte beats, INCR, normal access, bufferable/modifiable.
    assign m_awsize  = 3'b011;
    assign m_awburst = 2'b01;
    assign m_awlock  = 2'b00;
    assign m_awcache = 4'b0011;
    assign m_awprot  = 3'b000;
    assign m_awuser  = 5'b00000;

    // AW payload comes straight from the latched copies so it is stable for the whole AW phase.
    assign m_awaddr    = r_addr;
    assign m_awlen     = r_len;
    assign m_awid      = {{(8-IDX_W){1'b0}}, r_grant};
    assign m_wid       = {{(8-IDX_W){1'b0}}, r_grant};
    assign o_dbg_state = r_state;

    // Round-robin pick: first pending requester after the previous winner.
    always_comb begin
        int v_idx;
        w_any  = 1'b0;
        w_pick = '0;
        v_idx  = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            v_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
            if (!w_any && req_valid[v_idx]) begin
                w_any  = 1'b1;
                w_pick = IDX_W'(v_idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and channel outputs.
    always_comb begin
        w_next     = r_state;
        w_onehot   = '0;
        w_onehot[r_grant] = 1'b1;
        req_grant  = '0;
        wr_ready   = '0;
        done_valid = '0;
        done_resp  = 2'b00;
        m_awvalid  = 1'b0;
        m_wdata    = '0;
        m_wstrb    = '0;
        m_wlast    = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_next = S_AW_ISSUE;
            end
            S_AW_ISSUE: begin
                req_grant = w_onehot;
                m_awvalid = 1'b1;
                if (m_awready) w_next = S_W_STREAM;
            end
            S_W_STREAM: begin
                req_grant         = w_onehot;
                m_wvalid          = wr_valid[r_grant];
                m_wdata           = wr_data[int'(r_grant)*DATA_W +: DATA_W];
                m_wstrb           = wr_strb[int'(r_grant)*STRB_W +: STRB_W];
                m_wlast           = (r_beat_cnt == r_len);
                wr_ready[r_grant] = m_wready;
                if (m_wvalid && m_wready && m_wlast) w_next = S_B_WAIT;
            end
            S_B_WAIT: begin
                req_grant = w_onehot;
                m_bready  = 1'b1;
                if (m_bvalid) w_next = S_DONE;
            end
            S_DONE: begin
                req_grant           = w_onehot;
                done_valid[r_grant] = 1'b1;
                done_resp           = r_bresp;
                w_next              = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Burst context: owner, address/length copies, beat counter, response, round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant    <= '0;
            r_rr_ptr   <= IDX_W'(NUM_REQ - 1);
            r_addr     <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_bresp    <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_pick;
                        r_addr     <= req_addr[int'(w_pick)*ADDR_W +: ADDR_W];
                        r_len      <= req_len[int'(w_pick)*4 +: 4];
                        r_beat_cnt <= '0;
                    end
                end
                S_W_STREAM: begin
                    if (m_wvalid && m_wready) r_beat_cnt <= r_beat_cnt + 4'd1;
                end
                S_B_WAIT: begin
                    if (m_bvalid) r_bresp <= m_bresp;
                end
                S_DONE: begin
                    r_rr_ptr <= r_grant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_f2h_wr_burst_arbiter.sv
// Directed bench for f2h_wr_burst_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_f2h_wr_burst_arbiter;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    req_valid;
    logic [127:0]  req_addr;
    logic [15:0]   req_len;
    logic [3:0]    req_grant;
    logic [255:0]  wr_data;
    logic [31:0]   wr_strb;
    logic [3:0]    wr_valid;
    logic [3:0]    wr_ready;
    logic [3:0]    done_valid;
    logic [1:0]    done_resp;
    logic [7:0]    m_awid;
    logic [31:0]   m_awaddr;
    logic [3:0]    m_awlen;
    logic          m_awvalid;
    logic          m_awready;
    logic [2:0]    m_awsize;
    logic [1:0]    m_awburst;
    logic [1:0]    m_awlock;
    logic [3:0]    m_awcache;
    logic [2:0]    m_awprot;
    logic [4:0]    m_awuser;
    logic [7:0]    m_wid;
    logic [63:0]   m_wdata;
    logic [7:0]    m_wstrb;
    logic          m_wlast;
    logic          m_wvalid;
    logic          m_wready;
    logic [7:0]    m_bid;
    logic [1:0]    m_bresp;
    logic          m_bvalid;
    logic          m_bready;
    logic [2:0]    o_dbg_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    f2h_wr_burst_arbiter #(.NUM_REQ(NR), .ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_grant(req_grant),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .done_valid(done_valid), .done_resp(done_resp),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid),
        .m_awready(m_awready), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awlock(m_awlock),
        .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awuser(m_awuser),
        .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .o_dbg_state(o_dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input int g, input int b);
        return {8'hD0, 8'(g), 16'hBEEF, 8'(b), 8'(g), 8'h5A, 8'(b) ^ 8'hFF};
    endfunction

    function automatic logic [7:0] beat_strb(input int b);
        return 8'h0F ^ 8'(b * 17);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},  req_grant,  0);
        chk({tag, "_done"},   done_valid, 0);
        chk({tag, "_dresp"},  done_resp,  0);
        chk({tag, "_wready"}, wr_ready,   0);
        chk({tag, "_awvalid"}, m_awvalid, 0);
        chk({tag, "_awaddr"}, m_awaddr,   0);
        chk({tag, "_awlen"},  m_awlen,    0);
        chk({tag, "_awid"},   m_awid,     0);
        chk({tag, "_wvalid"}, m_wvalid,   0);
        chk({tag, "_wdata"},  m_wdata,    0);
        chk({tag, "_wstrb"},  m_wstrb,    0);
        chk({tag, "_wlast"},  m_wlast,    0);
        chk({tag, "_wid"},    m_wid,      0);
        chk({tag, "_bready"}, m_bready,   0);
        chk({tag, "_state"},  o_dbg_state, 0);
    endtask

    // Runs one complete burst for expected owner g. Entered 1 unit after a
    // rising edge with req_valid already set and the DUT in IDLE; returns
    // 1 unit after the edge that leaves DONE.
    task automatic do_burst(input int g, input logic [31:0] addr, input logic [3:0] len,
                            input int aw_delay, input bit bp, input logic [1:0] resp);
        logic [3:0] oh;
        int b, cyc, guard, nlast;
        bit v, wr;
        oh = 4'b0001 << g;
        req_addr[g*32 +: 32] = addr;
        req_len[g*4 +: 4]    = len;
        m_awready = (aw_delay == 0);
        m_wready  = 1'b1;
        wr_valid  = oh;
        wr_data[g*64 +: 64] = beat_data(g, 0);
        wr_strb[g*8 +: 8]   = beat_strb(0);
        @(posedge clk); @(negedge clk);
        chk("aw_latency", m_awvalid, 1);
        chk("grant",      req_grant, oh);
        chk("awid",       m_awid,    g);
        chk("awaddr",     m_awaddr,  addr);
        chk("awlen",      m_awlen,   len);
        chk("done_idle",  done_valid, 0);
        chk("no_w_pre_aw", m_wvalid, 0);
        chk("wready_pre_aw", wr_ready, 0);
        if (aw_delay > 0) begin
            repeat (aw_delay - 1) begin
                @(posedge clk); #1; @(negedge clk);
                chk("aw_hold_valid", m_awvalid, 1);
                chk("aw_hold_addr",  m_awaddr,  addr);
                chk("aw_hold_len",   m_awlen,   len);
                chk("aw_hold_now",   m_wvalid,  0);
            end
            @(posedge clk); #1;
            m_awready = 1'b1;
            @(negedge clk);
            chk("aw_hold_valid", m_awvalid, 1);
            chk("aw_hold_addr",  m_awaddr,  addr);
        end
        @(posedge clk); #1;
        m_awready = 1'b0;
        b = 0; cyc = 0; guard = 0; nlast = 0;
        while (b <= int'(len) && guard < 200) begin
            v  = bp ? (cyc % 3 != 1) : 1'b1;
            wr = bp ? (cyc % 2 == 0) : 1'b1;
            wr_valid = (bp ? ~oh : 4'b0000) | (v ? oh : 4'b0000);
            wr_data  = {4{64'hDEAD_0000_DEAD_0000}};
            wr_strb  = 32'h0;
            wr_data[g*64 +: 64] = beat_data(g, b);
            wr_strb[g*8 +: 8]   = beat_strb(b);
            m_wready = wr;
            @(negedge clk);
            chk("w_valid",   m_wvalid, v);
            chk("w_readymap", wr_ready, wr ? oh : 4'b0000);
            chk("w_wlast",   m_wlast, (b == int'(len)));
            chk("w_aw_off",  m_awvalid, 0);
            if (v) begin
                chk("w_data", m_wdata, beat_data(g, b));
                chk("w_strb", m_wstrb, beat_strb(b));
                chk("w_wid",  m_wid,   g);
            end
            if (v && wr && m_wlast) nlast++;
            @(posedge clk); #1;
            if (v && wr) b++;
            cyc++; guard++;
        end
        chk("w_timeout", (guard < 200), 1);
        chk("wlast_count", nlast, 1);
        wr_valid = 4'b0000;
        m_wready = 1'b0;
        @(negedge clk);
        chk("b_ready",  m_bready, 1);
        chk("b_wvalid", m_wvalid, 0);
        chk("b_grant",  req_grant, oh);
        @(posedge clk); #1;
        m_bvalid = 1'b1; m_bresp = resp; m_bid = 8'(g);
        @(negedge clk);
        chk("b_no_done", done_valid, 0);
        @(posedge clk); #1;
        m_bvalid = 1'b0; m_bresp = 2'b00; m_bid = 8'h00;
        @(negedge clk);
        chk("done_pulse", done_valid, oh);
        chk("done_resp",  done_resp,  resp);
        chk("done_grant", req_grant,  oh);
        chk("done_bready", m_bready,  0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5];
        reset = 1'b1;
        req_valid = '0; req_addr = '0; req_len = '0;
        wr_data = '0; wr_strb = '0; wr_valid = '0;
        m_awready = 1'b0; m_wready = 1'b0;
        m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;

        // Reset values and fixed attributes.
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        chk("awsize",  m_awsize,  3'b011);
        chk("awburst", m_awburst, 2'b01);
        chk("awlock",  m_awlock,  2'b00);
        chk("awcache", m_awcache, 4'b0011);
        chk("awprot",  m_awprot,  3'b000);
        chk("awuser",  m_awuser,  5'b00000);
        reset = 1'b0;

        // 1) Single burst from requester 0, awvalid one cycle after the request edge.
        req_valid = 4'b0001;
        do_burst(0, 32'h3000_0000, 4'd3, 0, 1'b0, 2'b00);
        req_valid = 4'b0000;

        // 2) All four held; requester 0 just won, so rotation starts at 1.
        order = '{1, 2, 3, 0, 1};
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            do_burst(order[k], 32'h3000_0000 + 32'(order[k]) * 32'h1000,
                     4'(order[k] + 1), 0, 1'b0, 2'b00);
        end
        req_valid = 4'b0000;

        // 3) Backpressure: AW held off 5 cycles, wready toggling, wr_valid gaps.
        req_valid = 4'b0100;
        do_burst(2, 32'h3000_2040, 4'd5, 5, 1'b1, 2'b00);
        req_valid = 4'b0000;

        // 4a) Single-beat burst with SLVERR, then no retry.
        req_valid = 4'b1000;
        do_burst(3, 32'h3000_3FF8, 4'd0, 0, 1'b0, 2'b10);
        req_valid = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            chk("no_retry_aw",    m_awvalid, 0);
            chk("no_retry_grant", req_grant, 0);
        end
        @(posedge clk); #1;

        // 4b) Sixteen-beat burst with backpressure.
        req_valid = 4'b0001;
        do_burst(0, 32'h3000_5000, 4'd15, 2, 1'b1, 2'b00);
        req_valid = 4'b0000;

        // 5) Reset after two beats of a burst from requester 0.
        req_valid = 4'b0001;
        req_addr[31:0] = 32'h3000_8000;
        req_len[3:0]   = 4'd7;
        m_awready = 1'b1; m_wready = 1'b1; wr_valid = 4'b0001;
        wr_data[63:0] = beat_data(0, 0); wr_strb[7:0] = beat_strb(0);
        @(posedge clk); @(negedge clk);
        chk("abort_grant", req_grant, 4'b0001);
        @(posedge clk); #1;
        m_awready = 1'b0;
        @(negedge clk);
        chk("abort_beat0", m_wdata, beat_data(0, 0));
        @(posedge clk); #1;
        wr_data[63:0] = beat_data(0, 1); wr_strb[7:0] = beat_strb(1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk_all_zero("abort");
        req_valid = 4'b0011;
        m_wready = 1'b0; wr_valid = 4'b0000;
        @(negedge clk);
        chk("abort_rst_done", done_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        // Without the pointer reset, requester 1 would win here.
        do_burst(0, 32'h3000_8000, 4'd7, 0, 1'b0, 2'b00);
        req_valid = 4'b0010;
        do_burst(1, 32'h3000_9000, 4'd2, 1, 1'b0, 2'b01);
        req_valid = 4'b0000;

        @(negedge clk);
        chk("end_idle", o_dbg_state, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
